// File: rtl/vram_arbiter.sv
// Three-way VRAM arbiter (initializer, video fetch, CPU) driving an async SRAM
// with a fixed IDLE -> ACC1 -> ACC2 access sequence and a registered strobe bus.
module vram_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter bit ROM_WP     = 1'b1
) (
    input  logic        clk28,
    input  logic        rst,
    input  logic        init_req,
    input  logic [18:0] init_addr,
    input  logic [7:0]  init_data,
    output logic        init_ack,
    input  logic        vid_req,
    input  logic [18:0] vid_addr,
    output logic [7:0]  vid_data,
    output logic        vid_valid,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [18:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack,
    output logic        cpu_wait,
    output logic [18:0] sram_a,
    input  logic [7:0]  sram_din,
    output logic [7:0]  sram_dout,
    output logic        sram_doe,
    output logic        sram_n_rd,
    output logic        sram_n_wr
);

    typedef enum logic [1:0] {IDLE, ACC1, ACC2} state_t;
    typedef enum logic [1:0] {OWN_INIT, OWN_VID, OWN_CPU} owner_t;

    localparam int CW = $clog2(STARVE_MAX + 2);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    state_t        state, state_nxt;
    owner_t        owner;
    logic [CW-1:0] starve;
    logic          req_i, req_v, req_c;
    logic          gnt_init, gnt_vid, gnt_cpu, grant;
    logic [18:0]   g_addr;
    logic [7:0]    g_wdata;
    logic          g_wr, g_prot;

    // A requester whose ack is pulsing this cycle still holds its level request;
    // it is ignored so the same access is not served twice.
    assign req_i = init_req & ~init_ack;
    assign req_v = vid_req  & ~vid_valid;
    assign req_c = cpu_req  & ~cpu_ack;

    always_comb begin
        state_nxt = state;
        gnt_init  = 1'b0;
        gnt_vid   = 1'b0;
        gnt_cpu   = 1'b0;
        case (state)
            IDLE: begin
                if (req_i)                           gnt_init = 1'b1;
                else if (req_c && starve >= STARVE_LIM) gnt_cpu = 1'b1;
                else if (req_v)                      gnt_vid  = 1'b1;
                else if (req_c)                      gnt_cpu  = 1'b1;
                if (gnt_init | gnt_vid | gnt_cpu) state_nxt = ACC1;
            end
            ACC1:    state_nxt = ACC2;
            ACC2:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign grant   = gnt_init | gnt_vid | gnt_cpu;
    assign g_addr  = gnt_init ? init_addr : (gnt_vid ? vid_addr : cpu_addr);
    assign g_wdata = gnt_init ? init_data : cpu_wdata;
    assign g_wr    = gnt_init | (gnt_cpu & cpu_wr);
    // Protected CPU writes still run the full cycle, only the write strobe is withheld.
    assign g_prot  = gnt_cpu & cpu_wr & ROM_WP & (cpu_addr[18:17] == 2'b00);

    assign cpu_wait = ~rst & cpu_req & ~cpu_ack & ~((state != IDLE) & (owner == OWN_CPU));

    always_ff @(posedge clk28) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= OWN_INIT;
            starve    <= '0;
            sram_a    <= '0;
            sram_dout <= '0;
            sram_doe  <= 1'b0;
            sram_n_rd <= 1'b1;
            sram_n_wr <= 1'b1;
            init_ack  <= 1'b0;
            vid_valid <= 1'b0;
            cpu_ack   <= 1'b0;
            vid_data  <= '0;
            cpu_rdata <= '0;
        end else begin
            state     <= state_nxt;
            init_ack  <= 1'b0;
            vid_valid <= 1'b0;
            cpu_ack   <= 1'b0;

            if (!cpu_req || gnt_cpu)
                starve <= '0;
            else if (gnt_vid && starve < STARVE_LIM)
                starve <= starve + CW'(1);

            case (state)
                IDLE: begin
                    if (grant) begin
                        owner     <= gnt_init ? OWN_INIT : (gnt_vid ? OWN_VID : OWN_CPU);
                        sram_a    <= g_addr;
                        sram_n_rd <= g_wr;
                        sram_doe  <= g_wr;
                        sram_n_wr <= ~(g_wr & ~g_prot);
                        if (g_wr) sram_dout <= g_wdata;
                    end
                end
                ACC1: sram_n_wr <= 1'b1;
                ACC2: begin
                    sram_n_rd <= 1'b1;
                    sram_n_wr <= 1'b1;
                    sram_doe  <= 1'b0;
                    case (owner)
                        OWN_INIT: init_ack <= 1'b1;
                        OWN_VID: begin
                            vid_valid <= 1'b1;
                            vid_data  <= sram_din;
                        end
                        OWN_CPU: begin
                            cpu_ack <= 1'b1;
                            if (!sram_n_rd) cpu_rdata <= sram_din;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: stimulus pushes expected acks, a negedge
// monitor pops and checks owner, data and arrival cycle.
module tb_vram_arbiter;

    logic        clk28 = 1'b0;
    logic        rst;
    logic        init_req, init_ack;
    logic [18:0] init_addr;
    logic [7:0]  init_data;
    logic        vid_req, vid_valid;
    logic [18:0] vid_addr;
    logic [7:0]  vid_data;
    logic        cpu_req, cpu_wr, cpu_ack, cpu_wait;
    logic [18:0] cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic [18:0] sram_a;
    logic [7:0]  sram_din, sram_dout;
    logic        sram_doe, sram_n_rd, sram_n_wr;

    vram_arbiter #(.STARVE_MAX(4), .ROM_WP(1'b1)) dut (
        .clk28(clk28), .rst(rst),
        .init_req(init_req), .init_addr(init_addr), .init_data(init_data), .init_ack(init_ack),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_valid(vid_valid),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_wait(cpu_wait),
        .sram_a(sram_a), .sram_din(sram_din), .sram_dout(sram_dout),
        .sram_doe(sram_doe), .sram_n_rd(sram_n_rd), .sram_n_wr(sram_n_wr)
    );

    always #5 clk28 = ~clk28;

    // SRAM stand-in: read data is the low address byte xor A5.
    assign sram_din = sram_a[7:0] ^ 8'hA5;

    typedef struct {
        int       who;
        logic [7:0] data;
        bit       chk_data;
        int       cyc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    always @(posedge clk28) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int who, input logic [7:0] d, input bit cd, input int c);
        exp_t e;
        e.who = who; e.data = d; e.chk_data = cd; e.cyc = c;
        sb.push_back(e);
    endtask

    always @(negedge clk28) begin
        int   n;
        int   who;
        logic [7:0] d;
        exp_t e;
        if (!rst) begin
            n = int'(init_ack) + int'(vid_valid) + int'(cpu_ack);
            if (n > 0) check("one_ack", n, 1);
            if (n == 1) begin
                who = init_ack ? 0 : (vid_valid ? 1 : 2);
                d   = vid_valid ? vid_data : cpu_rdata;
                if (sb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_ack: owner %0d, nothing expected (cycle %0d)", who, cyc);
                end else begin
                    e = sb.pop_front();
                    check("ack_owner", who, e.who);
                    check("ack_cycle", cyc, e.cyc);
                    if (e.chk_data) check("ack_data", d, e.data);
                end
            end
        end
    end

    task automatic wait_ack_drop(input int who, input int budget);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk28);
            seen = (who == 0) ? init_ack : ((who == 1) ? vid_valid : cpu_ack);
        end
        if (!seen) begin
            tests++; fails++;
            $display("FAIL ack_timeout: owner %0d got no ack, required one within %0d cycles", who, budget);
        end
        @(posedge clk28); #1;
        if (who == 0) init_req = 1'b0;
        else if (who == 1) vid_req = 1'b0;
        else cpu_req = 1'b0;
    endtask

    initial begin
        int  base;
        bit  wait_ok;
        rst = 1'b1;
        init_req = 1'b1; init_addr = '0; init_data = '0;
        vid_req = 1'b1;  vid_addr = '0;
        cpu_req = 1'b1;  cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;

        // Reset state with all requests pending
        repeat (3) @(negedge clk28);
        check("rst_n_rd", sram_n_rd, 1);
        check("rst_n_wr", sram_n_wr, 1);
        check("rst_doe", sram_doe, 0);
        check("rst_addr", sram_a, 0);
        check("rst_dout", sram_dout, 0);
        check("rst_acks", {init_ack, vid_valid, cpu_ack}, 0);
        check("rst_cpu_wait", cpu_wait, 0);
        check("rst_data", {vid_data, cpu_rdata}, 0);
        init_req = 1'b0; vid_req = 1'b0; cpu_req = 1'b0;
        @(negedge clk28); rst = 1'b0;
        repeat (2) @(negedge clk28);

        // CPU read, 2-cycle read strobe, ack 3 cycles after grant
        cpu_wr = 1'b0; cpu_addr = 19'h7C000; cpu_req = 1'b1;
        push(2, 8'hA5, 1'b1, cyc + 3);
        #1 check("cpu_wait_pending", cpu_wait, 1);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk28);
            check("rd_strobe", sram_n_rd, (k < 3) ? 0 : 1);
            if (k == 1) begin
                check("cpu_wait_granted", cpu_wait, 0);
                check("rd_addr", sram_a, 19'h7C000);
            end
        end
        @(posedge clk28); #1 cpu_req = 1'b0;
        repeat (2) @(negedge clk28);

        // Simultaneous requests: init, vid, cpu, acks 3 cycles apart
        init_addr = 19'h00100; init_data = 8'h11; init_req = 1'b1;
        vid_addr = 19'h00010; vid_req = 1'b1;
        cpu_wr = 1'b0; cpu_addr = 19'h40022; cpu_req = 1'b1;
        push(0, 8'h00, 1'b0, cyc + 3);
        push(1, 8'hB5, 1'b1, cyc + 6);
        push(2, 8'h87, 1'b1, cyc + 9);
        fork
            wait_ack_drop(0, 20);
            wait_ack_drop(1, 20);
            wait_ack_drop(2, 20);
        join
        repeat (2) @(negedge clk28);

        // Starvation: init and vid held, CPU gets in after 4 video grants
        init_addr = 19'h00200; init_data = 8'h22; init_req = 1'b1;
        vid_addr = 19'h00033; vid_req = 1'b1;
        cpu_wr = 1'b0; cpu_addr = 19'h40001; cpu_req = 1'b1;
        base = cyc;
        for (int k = 1; k <= 10; k++) begin
            if (k == 10)    push(2, 8'hA4, 1'b1, base + 3 * k);
            else if (k % 2) push(0, 8'h00, 1'b0, base + 3 * k);
            else            push(1, 8'h96, 1'b1, base + 3 * k);
        end
        wait_ok = 1'b1;
        while (cyc < base + 27) begin
            @(negedge clk28);
            if (cpu_wait !== 1'b1) wait_ok = 1'b0;
        end
        check("cpu_wait_starved", wait_ok, 1);
        @(posedge clk28); #1 init_req = 1'b0; vid_req = 1'b0;
        @(negedge clk28);
        check("starve_cpu_granted", cpu_wait, 0);
        check("starve_cpu_addr", sram_a, 19'h40001);
        while (cyc < base + 30) @(negedge clk28);
        @(posedge clk28); #1 cpu_req = 1'b0;
        repeat (2) @(negedge clk28);

        // Write-protected CPU write: no write strobe, still acked
        cpu_wr = 1'b1; cpu_addr = 19'h01234; cpu_wdata = 8'h5A; cpu_req = 1'b1;
        push(2, 8'h00, 1'b0, cyc + 3);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk28);
            check("wp_n_wr", sram_n_wr, 1);
            if (k < 3) check("wp_doe", sram_doe, 1);
        end
        @(posedge clk28); #1 cpu_req = 1'b0;
        @(negedge clk28);

        // Unprotected CPU write: write strobe low for ACC1 only
        cpu_addr = 19'h61234; cpu_req = 1'b1;
        push(2, 8'h00, 1'b0, cyc + 3);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk28);
            check("wr_n_wr", sram_n_wr, (k == 1) ? 0 : 1);
            check("wr_doe", sram_doe, (k < 3) ? 1 : 0);
            if (k == 1) check("wr_dout", sram_dout, 8'h5A);
        end
        @(posedge clk28); #1 cpu_req = 1'b0;
        @(negedge clk28);

        // Init write into the protected region is never blocked
        init_addr = 19'h00050; init_data = 8'h33; init_req = 1'b1;
        push(0, 8'h00, 1'b0, cyc + 3);
        @(negedge clk28);
        check("init_wr_unprot", sram_n_wr, 0);
        check("init_wr_dout", sram_dout, 8'h33);
        wait_ack_drop(0, 10);
        @(negedge clk28);

        // Reset during ACC2 aborts the read without an ack
        cpu_wr = 1'b0; cpu_addr = 19'h40005; cpu_req = 1'b1;
        repeat (2) @(negedge clk28);
        rst = 1'b1; cpu_req = 1'b0;
        @(negedge clk28);
        check("abort_n_rd", sram_n_rd, 1);
        check("abort_no_ack", cpu_ack, 0);
        @(negedge clk28);
        rst = 1'b0;
        @(negedge clk28);
        check("abort_no_late_ack", cpu_ack, 0);
        vid_addr = 19'h00077; vid_req = 1'b1;
        push(1, 8'hD2, 1'b1, cyc + 3);
        wait_ack_drop(1, 10);

        repeat (3) @(negedge clk28);
        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
